// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial operand datapath.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // A length of 0, or one wider than the operands, means "send every bit".
  function automatic int norm_len(input int len, input int width);
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand front end: emits A/B LSB-first with vld/last framing.
// Latency: bit 0 of an accepted frame appears the cycle after the accept edge.
// Backpressure: in_ready drops only while the one-entry holding stage is full; no downstream stall.
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int LW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LW-1:0]    in_len,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  ser_state_t state;
  ser_state_t next_state;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [LW-1:0]    cnt;

  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  logic [LW-1:0]    hold_len;
  logic             hold_full;

  logic             accept;
  logic             final_bit;
  logic [LW-1:0]    in_len_n;

  // Control strobes produced by the next-state logic.
  logic load_in;
  logic load_hold;
  logic do_shift;
  logic hold_wr;

  // Ready is held low during reset so nothing is counted as accepted then.
  assign in_ready  = rst & ~hold_full;
  assign accept    = in_vld & in_ready;
  assign final_bit = (state == SHIFT) && (cnt == LW'(1));
  assign in_len_n  = LW'(norm_len(int'(in_len), WIDTH));

  // Outputs come straight from registers: no input-to-output path.
  assign vld  = (state == SHIFT);
  assign a    = sh_a[0];
  assign b    = sh_b[0];
  assign last = final_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes; on the final bit the held frame beats a new one.
  always_comb begin
    next_state = state;
    load_in    = 1'b0;
    load_hold  = 1'b0;
    do_shift   = 1'b0;
    hold_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load_in    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LW'(1)) begin
          if (hold_full) begin
            load_hold = 1'b1;
          end else if (accept) begin
            load_in = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          do_shift = 1'b1;
          hold_wr  = accept;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift stage: load from input or holding stage, otherwise shift toward bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_a <= '0;
      sh_b <= '0;
      cnt  <= '0;
    end else if (load_in) begin
      sh_a <= in_a;
      sh_b <= in_b;
      cnt  <= in_len_n;
    end else if (load_hold) begin
      sh_a <= hold_a;
      sh_b <= hold_b;
      cnt  <= hold_len;
    end else if (do_shift) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      cnt  <= cnt - LW'(1);
    end
  end

  // Holding stage: filled by an accept mid-frame, drained into the shift stage on the final bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_a    <= '0;
      hold_b    <= '0;
      hold_len  <= '0;
      hold_full <= 1'b0;
    end else if (hold_wr) begin
      hold_a    <= in_a;
      hold_b    <= in_b;
      hold_len  <= in_len_n;
      hold_full <= 1'b1;
    end else if (load_hold) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: frame-queue reference model plus directed literal checks.
// Latency: model expects bit 0 the cycle after accept and contiguous frames.
// Backpressure: model expects in_ready low only while two frames are outstanding.
module tb_serial_operand_serializer;

  logic       clk;
  logic       rst;
  logic       in_vld;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_len;
  logic       vld;
  logic       a;
  logic       b;
  logic       last;

  int total = 0;
  int bad   = 0;

  serial_operand_serializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_len   (in_len),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .last     (last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding frames; the head is being sent, bit index pos.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         ql[$];
  int         pos = 0;

  function automatic int ref_len(input logic [3:0] l);
    return (l == 0 || l > 8) ? 8 : int'(l);
  endfunction

  always @(posedge clk) begin
    bit take;
    if (!rst) begin
      qa.delete();
      qb.delete();
      ql.delete();
      pos = 0;
    end else begin
      take = in_vld && (ql.size() < 2);
      if (ql.size() > 0) begin
        if (pos == ql[0] - 1) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
          void'(ql.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (take) begin
        qa.push_back(in_a);
        qb.push_back(in_b);
        ql.push_back(ref_len(in_len));
      end
    end
  end

  // Per-cycle logs for the directed checks.
  bit vld_log[$];
  bit last_log[$];
  bit rdy_log[$];

  logic [7:0] acc_a;
  logic [7:0] acc_b;

  // Compare process: checks every cycle, mid-cycle after inputs settle.
  always @(negedge clk) begin
    bit         ev;
    bit         er;
    logic [7:0] fa;
    logic [7:0] fb;
    logic [8:0] got_sum;
    logic [8:0] exp_sum;
    logic       c;
    #2;
    ev = (ql.size() > 0);
    er = rst && (ql.size() < 2);
    check("vld", 16'(vld), 16'(ev));
    check("in_ready", 16'(in_ready), 16'(er));
    vld_log.push_back(vld);
    last_log.push_back(last);
    rdy_log.push_back(in_ready);
    if (ev) begin
      fa = qa[0];
      fb = qb[0];
      check("a_bit", 16'(a), 16'(fa[pos]));
      check("b_bit", 16'(b), 16'(fb[pos]));
      check("last", 16'(last), 16'(pos == ql[0] - 1));
      acc_a[pos] = a;
      acc_b[pos] = b;
      if (pos == ql[0] - 1) begin
        c = 1'b0;
        got_sum = '0;
        for (int i = 0; i < ql[0]; i++) begin
          got_sum[i] = acc_a[i] ^ acc_b[i] ^ c;
          c = (acc_a[i] & acc_b[i]) | (c & (acc_a[i] ^ acc_b[i]));
        end
        exp_sum = ({1'b0, fa} + {1'b0, fb}) & ((9'h1 << ql[0]) - 9'h1);
        check("serial_sum", 16'(got_sum), 16'(exp_sum));
      end
    end
  end

  // Offer a frame from a negedge; returns at the negedge after it was accepted.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tl, input bit keep);
    bit got;
    got    = 1'b0;
    in_vld = 1'b1;
    in_a   = ta;
    in_b   = tb;
    in_len = tl;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      got = in_ready;
      @(negedge clk);
    end
    if (!keep) in_vld = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready expected accept at %0t", $time);
    end
  endtask

  int seq_a[8] = '{1, 0, 1, 0, 1, 1, 0, 1};
  int seq_b[8] = '{0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    int cnt;
    int start;
    int i0;
    int nrdy;
    rst    = 1'b0;
    in_vld = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_len = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_vld", 16'(vld), 16'(0));
    check("rst_a", 16'(a), 16'(0));
    check("rst_b", 16'(b), 16'(0));
    check("rst_last", 16'(last), 16'(0));
    check("rst_ready", 16'(in_ready), 16'(0));
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("ready_after_rst", 16'(in_ready), 16'(1));
    @(negedge clk);

    // Basic frame, literal bit sequence.
    send(8'hB5, 8'h3C, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #3;
      check("basic_vld", 16'(vld), 16'(1));
      check("basic_a", 16'(a), 16'(seq_a[k]));
      check("basic_b", 16'(b), 16'(seq_b[k]));
      check("basic_last", 16'(last), 16'(k == 7));
      @(negedge clk);
    end
    #3;
    check("basic_end_vld", 16'(vld), 16'(0));
    @(negedge clk);

    // Single-bit frame, then zero length meaning full width.
    send(8'h01, 8'h01, 4'd1, 1'b0);
    #3;
    check("len1_all", 16'({vld, last, a, b}), 16'hF);
    @(negedge clk);
    #3;
    check("len1_end", 16'(vld), 16'(0));
    @(negedge clk);
    send(8'($urandom), 8'($urandom), 4'd0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (!vld) break;
      cnt++;
      @(negedge clk);
    end
    check("len0_cycles", 16'(cnt), 16'(8));
    repeat (3) @(negedge clk);

    // Back-to-back, in_vld held high across three len-3 frames.
    start = vld_log.size();
    send(8'h05, 8'h03, 4'd3, 1'b1);
    send(8'h02, 8'h07, 4'd3, 1'b1);
    send(8'h06, 8'h01, 4'd3, 1'b0);
    repeat (14) @(negedge clk);
    #3;
    i0 = -1;
    for (int i = start; i < vld_log.size(); i++) begin
      if (vld_log[i]) begin
        i0 = i;
        break;
      end
    end
    check("b2b_found", 16'(i0 >= 0), 16'(1));
    if (i0 >= 0 && i0 + 10 <= vld_log.size()) begin
      for (int j = 0; j < 10; j++) begin
        check("b2b_vld", 16'(vld_log[i0 + j]), 16'(j < 9));
        check("b2b_last", 16'(last_log[i0 + j]), 16'(j == 2 || j == 5 || j == 8));
      end
    end
    nrdy = 0;
    for (int i = start; i < rdy_log.size(); i++) if (!rdy_log[i]) nrdy++;
    check("b2b_ready_low_cycles", 16'(nrdy), 16'(4));
    @(negedge clk);

    // Reset mid-frame with a frame held.
    send(8'hFF, 8'h00, 4'd8, 1'b0);
    send(8'hAA, 8'h55, 4'd8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check("midrst_vld", 16'(vld), 16'(0));
    check("midrst_last", 16'(last), 16'(0));
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (vld) cnt++;
      @(negedge clk);
    end
    check("midrst_no_held", 16'(cnt), 16'(0));

    // Random frames, lengths 0..15, random gaps and held in_vld.
    for (int f = 0; f < 1000; f++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    in_vld = 1'b0;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Parallel-to-serial front end for the serial adder datapath. Accepts a pair of WIDTH-bit operands with a bit length over a valid/ready handshake. Emits them LSB-first, one bit pair per cycle, with `vld` and `last` framing, directly into the serial adder's `vld/a/b/last` inputs. A one-entry holding buffer allows back-to-back operand frames with no idle cycle between them.

## Interface
- `WIDTH`, 8: maximum operand width in bits; must be ≥ 2.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-low reset (sampled on posedge `clk`; `rst == 0` resets).
- `in_vld` input 1: upstream offers `in_a`, `in_b`, `in_len`.
- `in_ready` output 1: block can accept a frame this cycle.
- `in_a` input WIDTH: operand A, bit 0 sent first.
- `in_b` input WIDTH: operand B, bit 0 sent first.
- `in_len` input $clog2(WIDTH+1): number of bits to send; 1..WIDTH; 0 means WIDTH; values > WIDTH clamp to WIDTH.
- `vld` output 1: `a`, `b`, `last` carry a valid bit pair.
- `a` output 1: current bit of A.
- `b` output 1: current bit of B.
- `last` output 1: current bit pair is the final one of the frame; only meaningful with `vld = 1`.

## Operation
- Handshake: a frame transfers on a posedge where `in_vld & in_ready & rst`. Inputs are ignored otherwise.
- `in_ready = !hold_full` (combinational from registers). It is driven 0 while `rst == 0`.
- Storage consists of:
  - Shift stage: `sh_a`, `sh_b` (WIDTH), remaining-bit counter `cnt`, and state.
  - Holding stage: `hold_a`, `hold_b`, `hold_len`, `hold_full`.
- States (shared enum):
  - **IDLE**: nothing being sent; `vld = 0`.
  - **SHIFT**: a frame is being sent; `vld = 1` every cycle.
- Transitions:
  - IDLE + accept: load the frame into the shift stage and go to SHIFT. The holding stage stays empty.
  - SHIFT, not the final bit: shift right by 1 and decrement `cnt`. An accept in this cycle writes the holding stage.
  - SHIFT, final bit (`cnt == 1`), selection of the next frame in priority order:
    1. If `hold_full`, load the holding stage into the shift stage, clear `hold_full`, and stay in SHIFT.
    2. Otherwise, if a frame is accepted this cycle, load it directly into the shift stage and stay in SHIFT.
    3. Otherwise, go to IDLE.
  - If the final bit coincides with `hold_full`, `in_ready` is 0 that cycle, so at most one source is ever loaded.
- Outputs `a = sh_a[0]`, `b = sh_b[0]`, `last = vld & (cnt == 1)` are all driven from registers (no input-to-output combinational path).
- Length normalisation (0 or > WIDTH maps to WIDTH) happens at accept time. The stored length is always 1..WIDTH.

## Timing
- Reset values: `vld = 0`, `a = 0`, `b = 0`, `last = 0`, state IDLE, `hold_full = 0`, `cnt = 0`. `in_ready` is 1 in the first cycle after `rst` returns high.
- Latency: a frame accepted on edge T drives bit 0 in the cycle after T. Bit k appears k cycles later. `last` is high in the cycle of bit `len-1`.
- A frame occupies exactly `len` consecutive `vld` cycles.
- Back-to-back: if the next frame is held or accepted by the final-bit edge, its bit 0 follows `last` with no gap.
- Throughput: one bit pair per cycle sustained. The upstream side sees `in_ready = 0` only while the holding stage is full.
- `len == 1`: a single cycle with `vld = 1` and `last = 1`.
- Reset mid-frame: on any edge with `rst == 0`, the in-flight frame and the held frame are both discarded. Outputs return to reset values on that edge. No partial `last` is emitted.
- There is no downstream backpressure; the consumer must take one bit pair per `vld` cycle.

## Structure
- Package `serial_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t`.
  - Function `norm_len(len, WIDTH)` implementing the clamp/zero rule.
- The design is a single module with no sub-module; the holding stage is a plain register set inside the module.
- The integration top instantiates this block feeding the serial adder: `vld/a/b/last` connect 1:1, and `clk` is shared.

## Test plan
- **Basic frame:** reset, then accept A = 8'hB5, B = 8'h3C, len = 8. Expect 8 `vld` cycles with a = 1,0,1,0,1,1,0,1 and b = 0,0,1,1,1,1,0,0, `last` only on the 8th cycle, then `vld = 0`.
- **Short/zero length:** accept len = 1 (A = 1, B = 1), which gives one cycle with `vld = last = a = b = 1`. Then accept len = 0, which produces 8 cycles.
- **Back-to-back:** hold `in_vld` high for 3 frames of len 3. Expect 9 contiguous `vld` cycles, `last` on cycles 3, 6, 9, and `in_ready = 0` while the holding stage is full.
- **Holding priority:** while frame 1 is on its last bit with the holding stage full, keep `in_vld` high. Expect `in_ready = 0`, frame 2 to follow frame 1 directly, and the offered frame 3 to be accepted on the following cycle.
- **Reset mid-frame:** assert `rst = 0` at bit 3 of an 8-bit frame with a held frame pending. Expect `vld = last = 0` on the next edge and no held frame emitted after release.
- **End-to-end:** connect to the serial adder with random WIDTH-bit operands and lengths. Reassemble `sum` and compare against (A + B) mod 2^len across 1000 frames.
